// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit queue.
// Optional overflow flag is enabled in the top by defining UART_TX_QUEUE_OVF_EN.
package uart_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int BYTE_W        = 8;

    // Binary encoding; four states fit in two bits.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with registered count/full/empty flags.
// Pop on empty and push on full are ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = BYTE_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic [ADDR_W:0]   next_count;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        next_count = count;
        if (push && !pop) begin
            next_count = count + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            next_count = count - (ADDR_W+1)'(1);
        end
    end

    // Storage has no reset; only the pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= next_count;
            full  <= (next_count == (ADDR_W+1)'(DEPTH));
            empty <= (next_count == '0);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter through its go/ready handshake.
// Define UART_TX_QUEUE_OVF_EN to add a sticky overflow flag (ovf/ovf_clr).
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_go,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              busy
`ifdef UART_TX_QUEUE_OVF_EN
    ,
    output logic              ovf,
    input  logic              ovf_clr
`endif
);

    tx_state_t         state;
    logic              pop;
    logic [BYTE_W-1:0] head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign pop  = (state == IDLE) && !empty && tx_ready;
    assign busy = !empty || (state != IDLE);

    // The transmitter is not reset with us, so IDLE always waits for ready
    // before issuing; this resynchronises after a reset mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_go   <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= head;
                        tx_go   <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_go <= 1'b0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!tx_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_go <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_QUEUE_OVF_EN
    // A dropped write wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue (DEPTH=4) with a behavioural transmitter.
// Covers UART_TX_QUEUE_OVF_EN ports when that macro is defined.
module tb_uart_tx_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              tx_go;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              busy;
`ifdef UART_TX_QUEUE_OVF_EN
    logic              ovf;
    logic              ovf_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_go    (tx_go),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy)
`ifdef UART_TX_QUEUE_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Transmitter model: drops ready the cycle after go, busy for frame_len cycles.
    // stall forces ready low to emulate a frame already in flight.
    logic xmit_busy = 1'b0;
    int   xmit_cnt  = 0;
    int   frame_len = 20;
    logic stall     = 1'b0;

    assign tx_ready = !xmit_busy && !stall;

    always @(posedge clk) begin
        if (tx_go === 1'b1) begin
            xmit_busy <= 1'b1;
            xmit_cnt  <= frame_len;
        end else if (xmit_busy) begin
            if (xmit_cnt <= 1) xmit_busy <= 1'b0;
            xmit_cnt <= xmit_cnt - 1;
        end
    end

    logic [7:0] exp_q[$];
    int   go_count     = 0;
    int   cyc          = 0;
    int   fall_cyc     = -100;
    logic prev_go      = 1'b0;
    logic prev_xbusy   = 1'b0;
    bit   gap_check_en = 1'b0;

    always @(posedge clk) cyc++;

    // Scoreboard side: every go pops one expected byte.
    always @(negedge clk) begin
        if (prev_xbusy && !xmit_busy) fall_cyc = cyc;
        if (tx_go === 1'b1) begin
            go_count++;
            checkOutput("go_not_back_to_back", prev_go, 0);
            checkOutput("ready_at_go", tx_ready, 1);
            if (gap_check_en) checkOutput("ready_to_go_gap", (cyc - fall_cyc) >= 2, 1);
            checkOutput("go_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) checkOutput("tx_data", tx_data, exp_q.pop_front());
        end
        prev_go    = (tx_go === 1'b1);
        prev_xbusy = xmit_busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit accept);
        wr_en   = 1'b1;
        wr_data = data;
        if (accept) exp_q.push_back(data);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        @(negedge clk);
        while ((busy || !tx_ready) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_done", busy, 0);
        checkOutput("sb_empty", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_full",    full,    0);
        checkOutput("rst_empty",   empty,   1);
        checkOutput("rst_count",   count,   0);
        checkOutput("rst_tx_go",   tx_go,   0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_busy",    busy,    0);
        tick();

        $display("[TB] single byte");
        frame_len = 20;
        applyStimulus(8'h41, 1);
        @(negedge clk);
        checkOutput("lat_cycle1_go", tx_go, 0);
        checkOutput("lat_cycle1_busy", busy, 1);
        tick();
        @(negedge clk);
        checkOutput("lat_cycle2_go", tx_go, 1);
        wait_drain(200);
        checkOutput("single_go_count", go_count, 1);

        $display("[TB] burst ordering");
        gap_check_en = 1'b1;
        frame_len    = 30;
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1);
        wait_drain(1000);
        gap_check_en = 1'b0;
        checkOutput("burst_go_count", go_count, 6);

        $display("[TB] full and drop");
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'hA0 + 8'(i), i < 4);
            @(negedge clk);
            checkOutput("fill_count", count, (i < 4) ? i + 1 : 4);
            checkOutput("fill_full", full, i >= 3);
        end
`ifdef UART_TX_QUEUE_OVF_EN
        checkOutput("ovf_set", ovf, 1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        checkOutput("ovf_cleared", ovf, 0);
`endif
        tick();
        stall = 1'b0;
        wait_drain(500);
        checkOutput("drop_go_count", go_count, 10);

        $display("[TB] simultaneous write and pop");
        frame_len = 5;
        stall     = 1'b1;
        applyStimulus(8'hB0, 1);
        applyStimulus(8'hB1, 1);
        @(negedge clk);
        checkOutput("pre_simul_count", count, 2);
        tick();
        stall = 1'b0;
        applyStimulus(8'hB2, 1);
        @(negedge clk);
        checkOutput("simul_count", count, 2);
        wait_drain(500);
        checkOutput("simul_go_count", go_count, 13);

        for (int r = 0; r < 3; r++) begin
            stall = 1'b1;
            for (int k = 0; k < 4; k++) applyStimulus(8'(r * 16 + k * 3 + 1), 1);
            @(negedge clk);
            checkOutput("wrap_full", full, 1);
            tick();
            stall = 1'b0;
            wait_drain(500);
        end
        checkOutput("wrap_go_count", go_count, 25);

        $display("[TB] reset mid-operation");
        frame_len = 40;
        for (int i = 0; i < 4; i++) applyStimulus(8'hC0 + 8'(i), 1);
        repeat (5) tick();
        @(negedge clk);
        checkOutput("pre_rst_count", count, 3);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_empty",   empty,   1);
        checkOutput("midrst_count",   count,   0);
        checkOutput("midrst_tx_go",   tx_go,   0);
        checkOutput("midrst_busy",    busy,    0);
        checkOutput("midrst_tx_data", tx_data, 0);
        tick();
        repeat (10) tick();
        checkOutput("midrst_no_go", go_count, 26);
        frame_len = 10;
        applyStimulus(8'hD5, 1);
        wait_drain(500);
        checkOutput("midrst_go_count", go_count, 27);

        $display("[TB] stale transmitter");
        stall = 1'b1;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(8'hE7, 1);
        repeat (20) tick();
        @(negedge clk);
        checkOutput("stale_busy", busy, 1);
        checkOutput("stale_no_go", go_count, 27);
        tick();
        stall = 1'b0;
        wait_drain(200);
        checkOutput("stale_go_count", go_count, 28);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
